hs32_wb_master: RTL and testbench
=================================

Name: hs32_wb_master

Overview:
- Wishbone classic (B4, non-pipelined) initiator for the hs32 core's external bus port.
- Converts a single-outstanding valid/ready memory request from the core into one Wishbone cycle, and returns read data or error on a valid/ready response channel.
- Sits between the core's load/store unit and the management-side Wishbone fabric, on the opposite end of the wbs_* slave port the user project already exposes.
- Includes a bus timeout so a missing slave cannot hang the core.

Parameters:
- TIMEOUT, 255: cycles in BUS state before forced error termination; 0 disables the timeout.
- CNT_W, 8: timeout counter width; must satisfy 2**CNT_W > TIMEOUT.

Ports:
- wb_clk_i  input  1  sole clock; all logic on the rising edge
- wb_rst_i  input  1  reset, asynchronous, active-high
- req_valid  input  1  core request valid
- req_ready  output  1  block can accept a request
- req_we  input  1  1 = write, 0 = read
- req_addr  input  32  byte address
- req_wdata  input  32  write data
- req_sel  input  4  byte lane enables
- rsp_valid  output  1  response valid
- rsp_ready  input  1  core accepts the response
- rsp_rdata  output  32  read data; 0 for writes and errors
- rsp_err  output  1  bus error or timeout
- rsp_timeout  output  1  error was caused by timeout
- wbm_cyc_o  output  1  Wishbone cycle
- wbm_stb_o  output  1  Wishbone strobe
- wbm_we_o  output  1  Wishbone write enable
- wbm_sel_o  output  4  Wishbone byte selects
- wbm_adr_o  output  32  Wishbone address, word aligned
- wbm_dat_o  output  32  Wishbone write data
- wbm_dat_i  input  32  Wishbone read data
- wbm_ack_i  input  1  Wishbone acknowledge
- wbm_err_i  input  1  Wishbone error

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset wb_rst_i is asynchronous and active-high.
- Reset values, applied immediately on wb_rst_i and held while it is asserted:
  - state = IDLE
  - wbm_cyc_o, wbm_stb_o, wbm_we_o = 0
  - wbm_sel_o, wbm_adr_o, wbm_dat_o = 0
  - rsp_valid, rsp_err, rsp_timeout = 0; rsp_rdata = 0
  - timeout counter = 0
  - req_ready = 0 while reset is asserted, 1 in IDLE afterwards
- Reset during an active cycle drops cyc/stb asynchronously. Any pending response is discarded.
- All Wishbone and rsp_* outputs are registered. req_ready is combinational: it equals (state == IDLE).
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - Accept when req_valid && req_ready at edge N.
  - Latch wbm_we_o = req_we and wbm_sel_o = req_sel.
  - Latch wbm_adr_o = {req_addr[31:2], 2'b00}.
  - Latch wbm_dat_o = req_we ? req_wdata : 0.
  - Set wbm_cyc_o = wbm_stb_o = 1; they are visible from cycle N+1.
  - Go to BUS and clear the counter.
- BUS:
  - All wbm_* outputs stay stable until termination.
  - Counter increments by 1 each cycle.
  - If wbm_err_i = 1: rsp_err = 1, rsp_rdata = 0. err takes priority when err and ack arrive in the same cycle.
  - Else if wbm_ack_i = 1: rsp_err = 0, rsp_rdata = wbm_we_o ? 0 : wbm_dat_i.
  - Else if TIMEOUT != 0 and counter == TIMEOUT-1: rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
  - On any of the three terminations: cyc/stb/we = 0 on the next edge, rsp_valid = 1, go to RESP.
  - Termination is therefore at most TIMEOUT cycles after cyc rises.
  - Zero-wait slave (ack in the first BUS cycle): cyc is high for exactly 1 cycle and rsp_valid rises 2 cycles after acceptance.
- RESP:
  - rsp_valid and rsp_* hold stable until rsp_ready.
  - On rsp_valid && rsp_ready: clear rsp_valid, rsp_err and rsp_timeout, go to IDLE.
  - The next request can be accepted one cycle later.
  - No back-to-back Wishbone cycles; there is a minimum 1-cycle cyc gap.
- ack_i or err_i in IDLE or RESP: ignored, no state change.
- Only one transaction is outstanding at a time. The request channel is backpressured for the whole BUS and RESP duration.

Test Plan:
- Read, 0-wait slave: req addr=0x0000_1006, sel=0xF; slave acks the first stb cycle with dat=0xDEAD_BEEF -> wbm_adr_o=0x0000_1004, cyc high exactly 1 cycle, rsp_valid at acceptance+2, rsp_rdata=0xDEAD_BEEF, rsp_err=0.
- Write, 3-wait slave: addr=0x20, wdata=0x1234_5678, sel=0x3 -> we=1, sel=0x3 and dat=0x1234_5678 stable for 4 cycles, rsp_rdata=0, rsp_err=0; req_ready=0 throughout.
- Error and priority: slave asserts ack and err in the same cycle -> rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- Timeout, TIMEOUT=8, no slave response -> cyc drops after exactly 8 cycles, rsp_err=1, rsp_timeout=1; with TIMEOUT=0 cyc stays high for 1000 cycles.
- Response backpressure and spurious ack: hold rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready=0, extra ack pulses ignored; releasing rsp_ready returns the FSM to IDLE and a second read proceeds normally.
- Async reset mid-BUS: assert wb_rst_i between clock edges -> cyc/stb/rsp_valid go 0 immediately; after release req_ready=1 and a new read completes normally.

Source files
------------

// File: rtl/hs32_wb_master.sv
// hs32_wb_master: Wishbone classic (B4) initiator for the hs32 bus port.
// Turns one valid/ready request into one Wishbone cycle and returns the
// result on a valid/ready response channel, with a bus timeout.
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, async active-high reset
//   req_valid/ready/we/addr/wdata/sel   core request channel
//   rsp_valid/ready/rdata/err/timeout   core response channel
//   wbm_cyc_o/stb_o/we_o/sel_o/adr_o/dat_o  Wishbone outputs
//   wbm_dat_i/ack_i/err_i                   Wishbone inputs
module hs32_wb_master #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i
);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    // Last counter value before a forced termination; unused when TIMEOUT=0.
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT == 0) ? 0 : (TIMEOUT - 1));

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             timeout_hit;

    // Held low during reset even though state already reads IDLE.
    assign req_ready = (state == IDLE) && !wb_rst_i;

    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_sel_o   <= '0;
            wbm_adr_o   <= '0;
            wbm_dat_o   <= '0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wbm_we_o  <= req_we;
                        wbm_sel_o <= req_sel;
                        wbm_adr_o <= {req_addr[31:2], 2'b00};
                        wbm_dat_o <= req_we ? req_wdata : 32'h0;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        cnt       <= '0;
                        state     <= BUS;
                    end
                end
                BUS: begin
                    cnt <= cnt + 1'b1;
                    // err wins over a simultaneous ack.
                    if (wbm_err_i || wbm_ack_i || timeout_hit) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                        if (wbm_err_i) begin
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b0;
                            rsp_rdata   <= 32'h0;
                        end else if (wbm_ack_i) begin
                            rsp_err     <= 1'b0;
                            rsp_timeout <= 1'b0;
                            rsp_rdata   <= wbm_we_o ? 32'h0 : wbm_dat_i;
                        end else begin
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b1;
                            rsp_rdata   <= 32'h0;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid   <= 1'b0;
                        rsp_err     <= 1'b0;
                        rsp_timeout <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hs32_wb_master.sv
// tb_hs32_wb_master: self-checking bench for hs32_wb_master.
// Drives core requests and a scripted Wishbone slave; checks responses.
module tb_hs32_wb_master;

    logic        clk;
    logic        rst;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        ack;
    logic        err;

    logic        z_req_valid;
    logic        z_req_ready;
    logic        z_rsp_valid;
    logic [31:0] z_rsp_rdata;
    logic        z_rsp_err;
    logic        z_rsp_timeout;
    logic        z_cyc;
    logic        z_stb;
    logic        z_we;
    logic [3:0]  z_sel;
    logic [31:0] z_adr;
    logic [31:0] z_dat_o;
    logic [31:0] z_dat_i;
    logic        z_ack;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_chk;
    int   n_fail;

    hs32_wb_master #(.TIMEOUT(8), .CNT_W(4)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_sel    (req_sel),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .wbm_cyc_o  (cyc),
        .wbm_stb_o  (stb),
        .wbm_we_o   (we),
        .wbm_sel_o  (sel),
        .wbm_adr_o  (adr),
        .wbm_dat_o  (dat_o),
        .wbm_dat_i  (dat_i),
        .wbm_ack_i  (ack),
        .wbm_err_i  (err)
    );

    hs32_wb_master #(.TIMEOUT(0), .CNT_W(8)) dut_z (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .req_valid  (z_req_valid),
        .req_ready  (z_req_ready),
        .req_we     (1'b0),
        .req_addr   (32'h0000_0400),
        .req_wdata  (32'h0),
        .req_sel    (4'hF),
        .rsp_valid  (z_rsp_valid),
        .rsp_ready  (1'b1),
        .rsp_rdata  (z_rsp_rdata),
        .rsp_err    (z_rsp_err),
        .rsp_timeout(z_rsp_timeout),
        .wbm_cyc_o  (z_cyc),
        .wbm_stb_o  (z_stb),
        .wbm_we_o   (z_we),
        .wbm_sel_o  (z_sel),
        .wbm_adr_o  (z_adr),
        .wbm_dat_o  (z_dat_o),
        .wbm_dat_i  (z_dat_i),
        .wbm_ack_i  (z_ack),
        .wbm_err_i  (1'b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request and let it be accepted; returns #1 after the
    // accepting edge, i.e. in the first cycle with cyc high.
    task automatic issue(input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we    = w;
        req_addr  = a;
        req_wdata = d;
        req_sel   = s;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (req_ready !== 1'b0 || cyc !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: ready=%b cyc=%b rv=%b want 0 0 0",
                     req_ready, cyc, rsp_valid);
        end
        n_chk++;
        if (adr !== 32'h0 || sel !== 4'h0 || rsp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_vals: adr=%h sel=%h rdata=%h want 0",
                     adr, sel, rsp_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_chk++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: req_ready=%b want 1", req_ready);
        end
    endtask

    task automatic test_read_zero_wait;
        rsp_t e;
        exp_q.push_back('{32'hDEAD_BEEF, 1'b0, 1'b0});
        issue(1'b0, 32'h0000_1006, 32'hFFFF_FFFF, 4'hF);
        n_chk++;
        if (cyc !== 1'b1 || stb !== 1'b1 || we !== 1'b0 ||
            adr !== 32'h0000_1004 || dat_o !== 32'h0 ||
            rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rd0_bus: cyc=%b stb=%b we=%b adr=%h dat=%h rv=%b rr=%b",
                     cyc, stb, we, adr, dat_o, rsp_valid, req_ready);
        end
        ack   = 1'b1;
        dat_i = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        ack   = 1'b0;
        dat_i = 32'h0;
        n_chk++;
        if (cyc !== 1'b0 || rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rd0_timing: cyc=%b rsp_valid=%b want 0 1",
                     cyc, rsp_valid);
        end
        e = exp_q.pop_front();
        n_chk++;
        if (rsp_rdata !== e.rdata || rsp_err !== e.err ||
            rsp_timeout !== e.tmo) begin
            n_fail++;
            $display("FAIL rd0_rsp: got %h/%b/%b want %h/%b/%b",
                     rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.tmo);
        end
        @(posedge clk);
        #1;
        n_chk++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rd0_done: rv=%b rr=%b want 0 1",
                     rsp_valid, req_ready);
        end
    endtask

    task automatic test_write_wait3;
        rsp_t e;
        exp_q.push_back('{32'h0, 1'b0, 1'b0});
        dat_i = 32'h7777_7777;
        issue(1'b1, 32'h0000_0020, 32'h1234_5678, 4'h3);
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (cyc !== 1'b1 || we !== 1'b1 || sel !== 4'h3 ||
                dat_o !== 32'h1234_5678 || adr !== 32'h20 ||
                req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL wr_stable[%0d]: cyc=%b we=%b sel=%h dat=%h adr=%h rr=%b",
                         i, cyc, we, sel, dat_o, adr, req_ready);
            end
            if (i == 3) ack = 1'b1;
            @(posedge clk);
            #1;
        end
        ack = 1'b0;
        n_chk++;
        if (cyc !== 1'b0 || we !== 1'b0 || rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_term: cyc=%b we=%b rv=%b want 0 0 1",
                     cyc, we, rsp_valid);
        end
        e = exp_q.pop_front();
        n_chk++;
        if (rsp_rdata !== e.rdata || rsp_err !== e.err ||
            rsp_timeout !== e.tmo) begin
            n_fail++;
            $display("FAIL wr_rsp: got %h/%b/%b want %h/%b/%b",
                     rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.tmo);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_err_priority;
        rsp_t e;
        exp_q.push_back('{32'h0, 1'b1, 1'b0});
        issue(1'b0, 32'h0000_0040, 32'h0, 4'hF);
        @(posedge clk);
        #1;
        ack   = 1'b1;
        err   = 1'b1;
        dat_i = 32'hAAAA_5555;
        @(posedge clk);
        #1;
        ack = 1'b0;
        err = 1'b0;
        e = exp_q.pop_front();
        n_chk++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata ||
            rsp_err !== e.err || rsp_timeout !== e.tmo) begin
            n_fail++;
            $display("FAIL err_prio: rv=%b got %h/%b/%b want %h/%b/%b",
                     rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
                     e.rdata, e.err, e.tmo);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_timeout;
        rsp_t e;
        int   n;
        exp_q.push_back('{32'h0, 1'b1, 1'b1});
        issue(1'b0, 32'h0000_0080, 32'h0, 4'hF);
        n = 0;
        while (cyc === 1'b1 && n < 20) begin
            n++;
            @(posedge clk);
            #1;
        end
        n_chk++;
        if (n != 8) begin
            n_fail++;
            $display("FAIL tmo_len: cyc high %0d cycles want 8", n);
        end
        e = exp_q.pop_front();
        n_chk++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata ||
            rsp_err !== e.err || rsp_timeout !== e.tmo) begin
            n_fail++;
            $display("FAIL tmo_rsp: rv=%b got %h/%b/%b want %h/%b/%b",
                     rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
                     e.rdata, e.err, e.tmo);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_timeout_disabled;
        int low;
        @(posedge clk);
        #1;
        z_req_valid = 1'b1;
        @(posedge clk);
        #1;
        z_req_valid = 1'b0;
        low = 0;
        for (int i = 0; i < 1000; i++) begin
            if (z_cyc !== 1'b1) low++;
            @(posedge clk);
            #1;
        end
        n_chk++;
        if (low != 0) begin
            n_fail++;
            $display("FAIL tmo0_hold: cyc low %0d of 1000 cycles want 0", low);
        end
        z_ack   = 1'b1;
        z_dat_i = 32'h600D_F00D;
        @(posedge clk);
        #1;
        z_ack = 1'b0;
        n_chk++;
        if (z_rsp_valid !== 1'b1 || z_rsp_rdata !== 32'h600D_F00D ||
            z_rsp_err !== 1'b0 || z_rsp_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo0_rsp: rv=%b got %h/%b/%b want 1 600df00d/0/0",
                     z_rsp_valid, z_rsp_rdata, z_rsp_err, z_rsp_timeout);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure;
        rsp_t e;
        rsp_ready = 1'b0;
        exp_q.push_back('{32'h0000_55AA, 1'b0, 1'b0});
        issue(1'b0, 32'h0000_0100, 32'h0, 4'hF);
        ack   = 1'b1;
        dat_i = 32'h0000_55AA;
        @(posedge clk);
        #1;
        ack = 1'b0;
        e = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            n_chk++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata ||
                rsp_err !== e.err || rsp_timeout !== e.tmo ||
                req_ready !== 1'b0 || cyc !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: rv=%b %h/%b/%b rr=%b cyc=%b want %h/%b/%b",
                         i, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
                         req_ready, cyc, e.rdata, e.err, e.tmo);
            end
            ack   = 1'b1;
            err   = i[0];
            dat_i = 32'hBAD0_0000 + 32'(i);
            @(posedge clk);
            #1;
            ack = 1'b0;
            err = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        n_chk++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || cyc !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: rv=%b rr=%b cyc=%b want 0 1 0",
                     rsp_valid, req_ready, cyc);
        end
        exp_q.push_back('{32'hCAFE_F00D, 1'b0, 1'b0});
        issue(1'b0, 32'h0000_0207, 32'h0, 4'h1);
        n_chk++;
        if (adr !== 32'h0000_0204 || sel !== 4'h1 || cyc !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_rd2_bus: adr=%h sel=%h cyc=%b want 204 1 1",
                     adr, sel, cyc);
        end
        @(posedge clk);
        #1;
        ack   = 1'b1;
        dat_i = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        ack = 1'b0;
        e = exp_q.pop_front();
        n_chk++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata ||
            rsp_err !== e.err || rsp_timeout !== e.tmo) begin
            n_fail++;
            $display("FAIL bp_rd2_rsp: rv=%b got %h/%b/%b want %h/%b/%b",
                     rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
                     e.rdata, e.err, e.tmo);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_bus;
        rsp_t e;
        issue(1'b0, 32'h0000_0300, 32'h0, 4'hF);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_chk++;
        if (cyc !== 1'b0 || stb !== 1'b0 || rsp_valid !== 1'b0 ||
            req_ready !== 1'b0 || adr !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mid: cyc=%b stb=%b rv=%b rr=%b adr=%h want 0",
                     cyc, stb, rsp_valid, req_ready, adr);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_chk++;
        if (req_ready !== 1'b1 || cyc !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_after: rr=%b cyc=%b rv=%b want 1 0 0",
                     req_ready, cyc, rsp_valid);
        end
        exp_q.push_back('{32'h0BAD_CAFE, 1'b0, 1'b0});
        issue(1'b0, 32'h0000_0310, 32'h0, 4'hF);
        ack   = 1'b1;
        dat_i = 32'h0BAD_CAFE;
        @(posedge clk);
        #1;
        ack = 1'b0;
        e = exp_q.pop_front();
        n_chk++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata ||
            rsp_err !== e.err || rsp_timeout !== e.tmo) begin
            n_fail++;
            $display("FAIL rst_rd_rsp: rv=%b got %h/%b/%b want %h/%b/%b",
                     rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
                     e.rdata, e.err, e.tmo);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_addr    = 32'h0;
        req_wdata   = 32'h0;
        req_sel     = 4'h0;
        rsp_ready   = 1'b1;
        dat_i       = 32'h0;
        ack         = 1'b0;
        err         = 1'b0;
        z_req_valid = 1'b0;
        z_dat_i     = 32'h0;
        z_ack       = 1'b0;

        test_reset();
        test_read_zero_wait();
        test_write_wait3();
        test_err_priority();
        test_timeout();
        test_timeout_disabled();
        test_backpressure();
        test_reset_mid_bus();

        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: %0d left want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
